// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Arbitrates a single-port, synchronous-read instruction RAM between the core
// fetch port (read-only) and the loader/debug port (read/write). At most one
// access is granted per cycle. Read data returns one cycle after the grant.
// A burst counter limits how many contended loader grants can occur in a row
// before fetch is forced in. While l_lock is high, fetch is never granted.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   f_req/f_addr               fetch request (held until f_gnt)
//   f_gnt/f_stall              fetch accepted / fetch waiting
//   f_rvalid/f_rdata           fetch read response (cycle after grant)
//   l_req/l_we/l_lock          loader request, write select, exclusive mode
//   l_addr/l_wdata             loader address / write data
//   l_gnt/l_rvalid/l_rdata     loader accepted / read response
//   m_en/m_we/m_addr/m_wdata   memory access strobe and command
//   m_rdata                    memory read data, valid cycle after a read
// ---------------------------------------------------------------------------
module imem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_stall,
  // loader port
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic                  l_lock,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  // memory port
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] burst_cnt;
  logic             rsp_f;
  logic             rsp_l;

  // Word alignment drops the byte-offset bits of both request addresses.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{f_addr[1:0], l_addr[1:0]};

  // Grant decision. Every output is forced low while reset is asserted, so
  // the unknown state before the first reset edge never reaches the RAM.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants; no latch.
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (l_lock) begin
        l_gnt = l_req;
      end else if (f_req && (burst_cnt == BURST_LIMIT)) begin
        f_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
      end
    end
  end

  assign f_stall = rst_n & f_req & ~f_gnt;

  assign m_en    = f_gnt | l_gnt;
  assign m_we    = l_gnt & l_we;
  assign m_addr  = l_gnt ? {l_addr[ADDR_WIDTH-1:2], 2'b00} :
                   f_gnt ? {f_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign m_wdata = l_gnt ? l_wdata : '0;

  // Response state and starvation counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      burst_cnt <= '0;
      rsp_f     <= 1'b0;
      rsp_l     <= 1'b0;
    end else begin
      rsp_f <= f_gnt;
      rsp_l <= l_gnt & ~l_we;
      // Lock clears the counter so contention starts fresh once it drops.
      if (l_lock || !f_req || f_gnt) begin
        burst_cnt <= '0;
      end else if (l_gnt && (burst_cnt != BURST_LIMIT)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // A read in flight when reset asserts must not surface as rvalid.
  assign f_rvalid = rsp_f & rst_n;
  assign l_rvalid = rsp_l & rst_n;
  assign f_rdata  = f_rvalid ? m_rdata : '0;
  assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed scenarios followed by a randomized phase. A synchronous-read RAM
// sits behind the DUT. The bench holds a reference model with a streak count
// of contended loader grants, the expected pending responses, and a shadow
// copy of the RAM. Every cycle is compared against that model.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MAX_BURST = 4;

  logic          clk;
  logic          rst_n;
  logic          f_req, l_req, l_we, l_lock;
  logic [AW-1:0] f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, f_stall, l_gnt, l_rvalid, m_en, m_we;
  logic [DW-1:0] f_rdata, l_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_stall(f_stall),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents loaded into the RAM on every reset cycle.
  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h0030_0093;
      1: return 32'h0020_0113;
      2: return 32'h0020_81b3;
      3: return 32'h0000_0013;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  // 64-word synchronous-read RAM, write then read across edges.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (m_en) begin
      if (m_we) ram[m_addr[7:2]] <= m_wdata;
      else      m_rdata <= ram[m_addr[7:2]];
    end
  end

  // Reference model state
  int          vectors = 0;
  int          errors  = 0;
  int          streak  = 0;
  logic        exp_rsp_f = 1'b0, exp_rsp_l = 1'b0;
  logic [31:0] exp_rd_f = '0, exp_rd_l = '0;
  logic [31:0] shadow [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model to the state after the next rising edge.
  task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                      input logic lr, input logic lwe, input logic llk,
                      input logic [31:0] la, input logic [31:0] lwd);
    logic        eg_f, eg_l;
    logic [31:0] ea;
    @(negedge clk);
    rst_n = rst; f_req = fr; f_addr = fa; l_req = lr; l_we = lwe;
    l_lock = llk; l_addr = la; l_wdata = lwd;
    #1;
    eg_f = 1'b0;
    eg_l = 1'b0;
    if (rst) begin
      if (llk)                            eg_l = lr;
      else if (fr && streak >= MAX_BURST) eg_f = 1'b1;
      else if (lr)                        eg_l = 1'b1;
      else                                eg_f = fr;
    end
    ea = eg_l ? (la & ~32'h3) : (eg_f ? (fa & ~32'h3) : 32'h0);

    check("f_gnt",    32'(f_gnt),    32'(eg_f));
    check("l_gnt",    32'(l_gnt),    32'(eg_l));
    check("f_stall",  32'(f_stall),  32'(rst & fr & ~eg_f));
    check("m_en",     32'(m_en),     32'(eg_f | eg_l));
    check("m_we",     32'(m_we),     32'(eg_l & lwe));
    check("m_addr",   m_addr,        ea);
    check("m_wdata",  m_wdata,       eg_l ? lwd : 32'h0);
    check("f_rvalid", 32'(f_rvalid), 32'(rst & exp_rsp_f));
    check("f_rdata",  f_rdata,       (rst & exp_rsp_f) ? exp_rd_f : 32'h0);
    check("l_rvalid", 32'(l_rvalid), 32'(rst & exp_rsp_l));
    check("l_rdata",  l_rdata,       (rst & exp_rsp_l) ? exp_rd_l : 32'h0);

    if (!rst) begin
      exp_rsp_f = 1'b0;
      exp_rsp_l = 1'b0;
      streak    = 0;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    end else begin
      exp_rsp_f = eg_f;
      exp_rsp_l = eg_l & ~lwe;
      if (eg_f) exp_rd_f = shadow[fa[7:2]];
      if (eg_l) begin
        if (lwe) shadow[la[7:2]] = lwd;
        else     exp_rd_l = shadow[la[7:2]];
      end
      // Streak = contended loader grants since fetch last won or stopped asking.
      if (llk || !fr || eg_f) streak = 0;
      else if (eg_l && streak < MAX_BURST) streak++;
    end
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_lock = 1'b0; l_addr = '0; l_wdata = '0;

    // Reset with both requests pending, then first cycle after release.
    repeat (3) step(0, 1, 32'h10, 1, 0, 0, 32'h20, 32'h0);
    step(1, 1, 32'h10, 1, 0, 0, 32'h40, 32'h0);

    // Fetch-only stream over the preloaded program.
    for (int i = 0; i < 4; i++) step(1, 1, 32'(4 * i), 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    // Starvation guard: both requesting for 12 cycles.
    for (int i = 0; i < 12; i++)
      step(1, 1, 32'(8 * i), 1, 0, 0, 32'(4 * i + 32'h80), 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    // Lock with a burst pending, then drop lock.
    step(1, 1, 32'h4, 1, 0, 0, 32'h44, 32'h0);
    step(1, 1, 32'h4, 1, 0, 0, 32'h48, 32'h0);
    for (int i = 0; i < 10; i++) step(1, 1, 32'h4, 1, 0, 1, 32'(32'h50 + 4 * i), 32'h0);
    for (int i = 0; i < 6; i++)  step(1, 1, 32'h4, 1, 0, 0, 32'h60, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    // Loader write, read back, then misaligned fetch of the same word.
    step(1, 0, 32'h0, 1, 1, 0, 32'h8, 32'hDEAD_BEEF);
    step(1, 0, 32'h0, 1, 0, 0, 32'h8, 32'h0);
    step(1, 1, 32'h9, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    // Reset while a fetch read is in flight.
    step(1, 1, 32'hC, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'hC, 1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    // Randomized traffic, occasional lock and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 32'($urandom_range(0, 255)),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and sequencer for a single-port, synchronous-read instruction memory shared by two requesters: the core fetch port (read-only) and the loader/debug port (read/write), used to program and inspect instruction RAM. It sits between the fetch stage, the loader, and the instruction RAM macro. It grants at most one access per cycle and returns read data one cycle after the grant. A starvation guard stops a streaming loader from locking out fetch, unless the loader explicitly asserts lock.

## Interface
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 32, byte address width
- MAX_BURST, 4, consecutive contended loader grants allowed before fetch is forced in (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- f_req  in  1  fetch read request; held with f_addr until f_gnt
- f_addr  in  ADDR_WIDTH  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_WIDTH  fetch read data
- f_stall  out  1  f_req & ~f_gnt
- l_req  in  1  loader request; held with l_we/l_addr/l_wdata until l_gnt
- l_we  in  1  1 = write, 0 = read
- l_lock  in  1  loader exclusive mode; fetch never granted while high
- l_addr  in  ADDR_WIDTH  loader byte address
- l_wdata  in  DATA_WIDTH  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid (reads only)
- l_rdata  out  DATA_WIDTH  loader read data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_WIDTH  byte address, bits [1:0] forced to 0
- m_wdata  out  DATA_WIDTH  memory write data
- m_rdata  in  DATA_WIDTH  memory read data, valid the cycle after an m_en read

## Operation
- Grant decision is combinational from the requests and registered state. f_gnt and l_gnt are never both high.
- m_en = f_gnt | l_gnt. m_we = l_gnt & l_we. m_addr and m_wdata come from the granted requester. When nothing is granted, m_addr and m_wdata are 0.
- Priority:
  - l_lock=1: only the loader is granted.
  - Otherwise, if f_req=1 and burst_cnt == MAX_BURST: fetch wins.
  - Otherwise the loader wins if l_req=1, else fetch wins if f_req=1.
- burst_cnt is a register of width clog2(MAX_BURST+1):
  - +1 on each loader grant while f_req=1 (contended), saturating at MAX_BURST.
  - Cleared on any fetch grant, or in any cycle with f_req=0.
  - Not incremented while l_lock=1.
- Response tracking registers:
  - rsp_f is set for the next cycle on a fetch grant.
  - rsp_l is set for the next cycle on a loader read grant.
  - A loader write produces no rvalid; the write is complete at the grant edge.
- f_rvalid = rsp_f and l_rvalid = rsp_l. f_rdata and l_rdata equal m_rdata while their own rvalid is high, else 0.
- Misaligned addresses are not an error: low two bits are dropped and the access proceeds.
- Read-after-write to the same address from the loader in consecutive cycles returns the new data; this relies on the memory's write-then-read ordering across edges.

## Timing
- Grant latency: 0 cycles. A request asserted in cycle N with a free arbiter is granted in cycle N. The memory samples at the N→N+1 edge.
- Read latency: rvalid and rdata in cycle N+1. Throughput is one access per cycle, and back-to-back grants to the same requester are allowed.
- Reset, sampled at the edge with rst_n=0:
  - burst_cnt, rsp_f and rsp_l clear.
  - While rst_n=0, f_gnt, l_gnt, m_en, m_we, f_stall, f_rvalid and l_rvalid are all 0, and all data and address outputs are 0.
- Reset mid-operation: a read granted in the cycle before reset returns no rvalid. Requesters reissue after reset.
- Dropping l_lock: fetch becomes eligible in the same cycle. burst_cnt resumes from 0.
- Request withdrawn before grant: permitted. No state change results.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with f_req=l_req=1 -> all outputs 0. First cycle after release: l_gnt=1, f_gnt=0, f_stall=1.
- Fetch only: f_req=1, f_addr = 0, 4, 8, 12 on consecutive cycles, memory preloaded 0x00300093, 0x00200113, 0x002081b3, 0x00000013 -> f_gnt every cycle; f_rvalid on cycles 1–4 with those words in order.
- Starvation guard, MAX_BURST=4: f_req and l_req held for 12 cycles -> grant pattern L,L,L,L,F repeating; f_stall low exactly in the F cycles.
- Lock: l_lock=1, l_req and f_req held 10 cycles -> 10 loader grants, zero fetch grants. Drop lock with burst pending -> fetch granted only after 4 further loader grants if l_req stays high.
- Loader write then read: write 0xDEADBEEF to 0x8, then read 0x8, then fetch from 0x9 -> l_rvalid only on the read (data 0xDEADBEEF); fetch m_addr=0x8 and f_rdata=0xDEADBEEF.
- Reset during a pending read: grant a fetch at cycle N, assert rst_n=0 at N+1 -> f_rvalid=0 at N+1 and after.
